// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU command issuer.
package alu_issue_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 16;

  localparam logic [OP_W-1:0] OP_NOP = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // 19-bit queued command, packed as {a, b, op}
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [OP_W-1:0]   op);
    cmd_t c;
    c.a  = a;
    c.b  = b;
    c.op = op;
    return c;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries, registered read data, wrap-bit pointers.
module alu_cmd_fifo
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t wr_data,
  input  logic pop,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointer update and registered head read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        rd_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued ALU commands one at a time and returns result/op/err on a valid/ready port.
module alu_cmd_issuer
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [OP_W-1:0]   rsp_op,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t           state;
  state_t           state_nxt;
  cmd_t             fifo_rd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] to_cnt;
  logic             timeout_hit;
  logic             is_nop;

  logic             load_alu;
  logic             start_nxt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             rsp_load;
  logic             rsp_drop;
  logic [RES_W-1:0] rsp_result_nxt;
  logic [OP_W-1:0]  rsp_op_nxt;
  logic             rsp_err_nxt;

  assign cmd_ready   = !fifo_full;
  assign push        = cmd_valid && cmd_ready;
  assign busy        = (state != ST_IDLE) || !fifo_empty;
  assign is_nop      = (fifo_rd.op == OP_NOP);
  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (pack_cmd(cmd_a, cmd_b, cmd_op)),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; ISSUE is where the popped head becomes visible
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!fifo_empty) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = is_nop ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (alu_done || timeout_hit) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Control strobes for the datapath registers
  always_comb begin
    pop            = 1'b0;
    load_alu       = 1'b0;
    start_nxt      = 1'b0;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    rsp_load       = 1'b0;
    rsp_drop       = 1'b0;
    rsp_result_nxt = '0;
    rsp_op_nxt     = alu_op;
    rsp_err_nxt    = 1'b0;
    unique case (state)
      ST_IDLE: pop = !fifo_empty;
      ST_ISSUE: begin
        load_alu   = 1'b1;
        cnt_clr    = 1'b1;
        start_nxt  = !is_nop;
        rsp_load   = is_nop;
        rsp_op_nxt = fifo_rd.op;
      end
      ST_WAIT: begin
        if (alu_done) begin
          rsp_load       = 1'b1;
          rsp_result_nxt = alu_result;
        end else if (timeout_hit) begin
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_RESP: rsp_drop = rsp_ready;
      default: ;
    endcase
  end

  // ALU drive, timeout counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      to_cnt     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      alu_start <= start_nxt;
      if (load_alu) begin
        alu_a  <= fifo_rd.a;
        alu_b  <= fifo_rd.b;
        alu_op <= fifo_rd.op;
      end
      if (cnt_clr)      to_cnt <= '0;
      else if (cnt_inc) to_cnt <= to_cnt + CNT_W'(1);
      if (rsp_load) begin
        rsp_valid  <= 1'b1;
        rsp_result <= rsp_result_nxt;
        rsp_op     <= rsp_op_nxt;
        rsp_err    <= rsp_err_nxt;
      end else if (rsp_drop) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural single-cycle ALU.
module tb_alu_cmd_issuer;
  import alu_issue_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_err;
  logic              busy;

  logic alu_mute;
  logic force_done;

  typedef struct {
    logic [RES_W-1:0] res;
    logic [OP_W-1:0]  op;
    logic             err;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [RES_W-1:0]  res;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   checks    = 0;
  int   errors    = 0;
  int   start_cnt = 0;
  logic start_prev;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                               input logic [2:0] op);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // Single-cycle ALU stand-in; alu_mute suppresses done, force_done injects a stray one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done   <= 1'b0;
      alu_result <= '0;
    end else begin
      alu_done   <= (alu_start && !alu_mute) || force_done;
      alu_result <= alu_start ? alu_ref(alu_a, alu_b, alu_op) : 16'h0000;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response scoreboard and start-pulse monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_start) begin
        start_cnt++;
        chk("start_single_cycle", 32'(start_prev), 32'd0);
      end
      start_prev = alu_start;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got result %0h op %0h err %0b with nothing queued",
                   rsp_result, rsp_op, rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          chk("rsp_op", 32'(rsp_op), 32'(mon_e.op));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end else begin
      start_prev = 1'b0;
    end
  end

  // Drive one command (called just after a rising edge) and return after its handshake edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [15:0] res, input logic err);
    int   n = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      e.res = res;
      e.op  = op;
      e.err = err;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_alu_a"}, 32'(alu_a), 32'd0);
    chk({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_alu_start"}, 32'(alu_start), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
    chk({tag, "_rsp_op"}, 32'(rsp_op), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vecs(input int lo, input int hi, input string tag);
    int exp_starts = 0;
    start_cnt = 0;
    for (int i = lo; i <= hi; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, 1'b0);
      if (vecs[i].op != OP_NOP) exp_starts++;
    end
    cmd_valid = 1'b0;
    drain({tag, "_drain"});
    chk({tag, "_start_count"}, 32'(start_cnt), 32'(exp_starts));
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!alu_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(alu_start), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;

    vecs[0] = '{a: 8'hF0, b: 8'h3C, op: 3'b010, res: 16'h0030};
    vecs[1] = '{a: 8'hFF, b: 8'h0F, op: 3'b011, res: 16'h00F0};
    vecs[2] = '{a: 8'h01, b: 8'h01, op: 3'b001, res: 16'h0002};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, op: 3'b001, res: 16'h01FE};
    vecs[4] = '{a: 8'h00, b: 8'h00, op: 3'b001, res: 16'h0000};
    vecs[5] = '{a: 8'h05, b: 8'h07, op: 3'b101, res: 16'h0000};
    vecs[6] = '{a: 8'h09, b: 8'h09, op: 3'b000, res: 16'h0000};

    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    rsp_ready  = 1'b0;
    alu_mute   = 1'b0;
    force_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single add with cycle-exact latency
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_a     = 8'd200;
    cmd_b     = 8'd100;
    cmd_op    = 3'b001;
    exp_q.push_back('{res: 16'd300, op: 3'b001, err: 1'b0});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("lat_start_c%0d", c), 32'(alu_start), 32'(c == 2));
      chk($sformatf("lat_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c == 4));
      if (c == 2) chk("lat_alu_a", 32'(alu_a), 32'd200);
    end
    drain("single_drain");

    // Back-to-back commands, then the remaining table entries
    @(posedge clk);
    #1;
    run_vecs(0, 2, "b2b");
    @(posedge clk);
    #1;
    run_vecs(3, 6, "table");

    // Back-pressure: DEPTH queued plus one in flight fills the block
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(8'(i), 8'd10, 3'b001, 16'(i + 10), 1'b0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    fork
      send(8'(DEPTH + 1), 8'd10, 3'b001, 16'(DEPTH + 11), 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    cmd_valid = 1'b0;
    drain("full_drain");

    // Nop issues no start pulse
    @(posedge clk);
    #1;
    base = start_cnt;
    send(8'h12, 8'h34, 3'b000, 16'h0000, 1'b0);
    cmd_valid = 1'b0;
    drain("nop_drain");
    chk("nop_no_start", 32'(start_cnt), 32'(base));

    // Timeout, then a stray late done, then a normal command
    @(posedge clk);
    #1;
    alu_mute = 1'b1;
    send(8'd3, 8'd4, 3'b001, 16'h0000, 1'b1);
    cmd_valid = 1'b0;
    wait_start("to_start_seen");
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("to_wait_cycles", 32'(n), 32'(TIMEOUT));
    repeat (2) @(posedge clk);
    #1;
    force_done = 1'b1;
    @(posedge clk);
    #1;
    force_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("late_done_no_rsp", 32'(rsp_valid), 32'd0);
      chk("late_done_idle", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    alu_mute = 1'b0;
    send(8'd3, 8'd4, 3'b001, 16'd7, 1'b0);
    cmd_valid = 1'b0;
    drain("after_to_drain");

    // Reset while waiting with two commands queued
    @(posedge clk);
    #1;
    alu_mute = 1'b1;
    send(8'd1, 8'd2, 3'b001, 16'd3, 1'b0);
    send(8'd4, 8'd5, 3'b001, 16'd9, 1'b0);
    send(8'd6, 8'd7, 3'b001, 16'd13, 1'b0);
    cmd_valid = 1'b0;
    wait_start("rst_start_seen");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    alu_mute = 1'b0;
    @(posedge clk);
    #1;
    send(8'd200, 8'd55, 3'b001, 16'd255, 1'b0);
    cmd_valid = 1'b0;
    drain("after_rst_drain");
    repeat (10) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
